sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the board's external 16-bit asynchronous SRAM (20-bit word address, active-low CE/OE/WE/UB/LB). Port 0 serves the processor datapath. Port 1 serves the image loader/dumper host path. The block grants the SRAM to one requester at a time using round-robin and drives a fixed multi-cycle read or write sequence on the shared pins. It replaces direct pin ownership by the datapath and sits between the processor and the SRAM pads.

---
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter and access sequencer for async 16-bit SRAM
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [19:0] addr0,
    input  logic [19:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [1:0]  be0,
    input  logic [1:0]  be1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [1:0]  grant,
    output logic [19:0] sram_address,
    inout  wire  [15:0] bus,
    output logic        chip_en,
    output logic        output_enable,
    output logic        data_enable,
    output logic        UB,
    output logic        LB
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(ACCESS_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wait;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_we;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_be;

    logic        w_pick;
    logic        w_last_access;
    logic        w_bus_oe;
    logic [15:0] w_rd_masked;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        w_pick = 1'b0;
        if (req0 && req1) begin
            w_pick = ~r_last_grant;
        end else if (req1) begin
            w_pick = 1'b1;
        end
    end

    assign w_last_access = (r_wait == LAST_WAIT);
    assign w_rd_masked   = {r_be[1] ? bus[15:8] : 8'h00, r_be[0] ? bus[7:0] : 8'h00};
    assign bus           = w_bus_oe ? r_wdata : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req0 || req1) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_last_access) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        chip_en       = 1'b1;
        output_enable = 1'b1;
        data_enable   = 1'b1;
        UB            = 1'b1;
        LB            = 1'b1;
        sram_address  = 20'h00000;
        grant         = 2'b00;
        ack0          = 1'b0;
        ack1          = 1'b0;
        w_bus_oe      = 1'b0;
        if (r_state != S_IDLE) begin
            chip_en      = 1'b0;
            UB           = ~r_be[1];
            LB           = ~r_be[0];
            sram_address = r_addr;
            grant        = r_owner ? 2'b10 : 2'b01;
            w_bus_oe     = r_we;
        end
        case (r_state)
            S_SETUP: output_enable = r_we;
            S_ACCESS: begin
                output_enable = r_we;
                data_enable   = ~r_we;
            end
            S_DONE: begin
                ack0 = ~r_owner;
                ack1 = r_owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait       <= 4'd0;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 20'h00000;
            r_wdata      <= 16'h0000;
            r_be         <= 2'b00;
            rdata0       <= 16'h0000;
            rdata1       <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                        r_we         <= w_pick ? we1 : we0;
                        r_addr       <= w_pick ? addr1 : addr0;
                        r_wdata      <= w_pick ? wdata1 : wdata0;
                        r_be         <= w_pick ? be1 : be0;
                    end
                end
                S_SETUP: r_wait <= 4'd0;
                S_ACCESS: begin
                    if (!w_last_access) begin
                        r_wait <= r_wait + 4'd1;
                    end else if (!r_we) begin
                        if (r_owner) rdata1 <= w_rd_masked;
                        else         rdata0 <= w_rd_masked;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM model and access-level reference model
module tb_sram_arbiter;

    localparam int AC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, req1, we0, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  be0, be1;
    logic [15:0] rdata0, rdata1;
    logic        ack0, ack1;
    logic [1:0]  grant;
    logic [19:0] sram_address;
    wire  [15:0] bus;
    logic        chip_en, output_enable, data_enable, UB, LB;

    sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .rdata0(rdata0), .rdata1(rdata1),
        .ack0(ack0), .ack1(ack1), .grant(grant), .sram_address(sram_address),
        .bus(bus), .chip_en(chip_en), .output_enable(output_enable),
        .data_enable(data_enable), .UB(UB), .LB(LB)
    );

    // Asynchronous SRAM: drives on CE#&OE#, stores enabled bytes while CE#&WE# low.
    logic [15:0] sram_mem [256];
    assign bus = (!chip_en && !output_enable) ? sram_mem[sram_address[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!chip_en && !data_enable) begin
            if (!UB) sram_mem[sram_address[7:0]][15:8] <= bus[15:8];
            if (!LB) sram_mem[sram_address[7:0]][7:0]  <= bus[7:0];
        end
    end

    // Strobe-width sweep instances, write-only on port 0.
    localparam int SW_AC [2] = '{1, 15};
    logic        sw_req [2];
    logic        sw_de  [2];
    logic        sw_ack [2];
    logic [19:0] s_addr;
    logic [15:0] s_wd;
    for (genvar g = 0; g < 2; g++) begin : g_sw
        wire  [15:0] bus_w;
        logic [15:0] rd0, rd1;
        logic        a1, ce, oe, ub, lb;
        logic [1:0]  gr;
        logic [19:0] sa;
        sram_arbiter #(.ACCESS_CYCLES(SW_AC[g])) u (
            .clk(clk), .rst(rst),
            .req0(sw_req[g]), .req1(1'b0), .we0(1'b1), .we1(1'b0),
            .addr0(s_addr), .addr1(20'h0), .wdata0(s_wd), .wdata1(16'h0),
            .be0(2'b11), .be1(2'b00), .rdata0(rd0), .rdata1(rd1),
            .ack0(sw_ack[g]), .ack1(a1), .grant(gr), .sram_address(sa),
            .bus(bus_w), .chip_en(ce), .output_enable(oe),
            .data_enable(sw_de[g]), .UB(ub), .LB(lb)
        );
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: one access = phase 0 (setup), 1..AC (strobe), AC+1 (done); -1 = idle.
    int          m_ph = -1;
    bit          m_valid = 0;
    bit          m_own, m_last = 1, m_we;
    logic [19:0] m_addr;
    logic [15:0] m_wd, m_rd0, m_rd1;
    logic [1:0]  m_be;
    logic [15:0] ref_mem [256];

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_ph = -1; m_last = 1; m_rd0 = 16'h0; m_rd1 = 16'h0;
        end else if (m_ph < 0) begin
            if (req0 || req1) begin
                m_own  = (req0 && req1) ? !m_last : req1;
                m_last = m_own;
                m_we   = m_own ? we1 : we0;
                m_addr = m_own ? addr1 : addr0;
                m_wd   = m_own ? wdata1 : wdata0;
                m_be   = m_own ? be1 : be0;
                m_ph   = 0;
            end
        end else if (m_ph == AC + 1) begin
            m_ph = -1;
        end else begin
            if (m_ph == AC) begin
                if (m_we) begin
                    if (m_be[1]) ref_mem[m_addr[7:0]][15:8] = m_wd[15:8];
                    if (m_be[0]) ref_mem[m_addr[7:0]][7:0]  = m_wd[7:0];
                end else begin
                    logic [15:0] v;
                    v = ref_mem[m_addr[7:0]];
                    v = {m_be[1] ? v[15:8] : 8'h00, m_be[0] ? v[7:0] : 8'h00};
                    if (m_own) m_rd1 = v; else m_rd0 = v;
                end
            end
            m_ph = m_ph + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit act;
            act = (m_ph >= 0);
            chk("grant", grant, !act ? 2'b00 : (m_own ? 2'b10 : 2'b01));
            chk("ack0", ack0, act && m_ph == AC + 1 && !m_own);
            chk("ack1", ack1, act && m_ph == AC + 1 && m_own);
            chk("chip_en", chip_en, !act);
            chk("output_enable", output_enable, !(act && m_ph <= AC && !m_we));
            chk("data_enable", data_enable, !(m_ph >= 1 && m_ph <= AC && m_we));
            chk("UB", UB, act ? !m_be[1] : 1'b1);
            chk("LB", LB, act ? !m_be[0] : 1'b1);
            chk("sram_address", sram_address, act ? m_addr : 20'h0);
            chk("rdata0", rdata0, m_rd0);
            chk("rdata1", rdata1, m_rd1);
            if (act && m_we) chk("bus_wdata", bus, m_wd);
        end
    end

    task automatic access(input bit port, input bit we, input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] be, output int lat, output int de_low,
                          output logic [15:0] rd, output logic ub_s, output logic lb_s);
        bit done;
        @(posedge clk); #2;
        if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; be1 = be; end
        else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; be0 = be; end
        lat = 0; de_low = 0; done = 0; rd = 16'hxxxx; ub_s = 1'bx; lb_s = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            lat++;
            if (!data_enable) de_low++;
            if (!output_enable || !data_enable) begin ub_s = UB; lb_s = LB; end
            if (port ? ack1 : ack0) begin
                done = 1;
                rd = port ? rdata1 : rdata0;
            end
        end
        chk("access_done", done, 1'b1);
        @(posedge clk); #2;
        req0 = 0; req1 = 0;
    endtask

    initial begin
        int lat, dl, n;
        int t [3];
        logic [1:0] gs [4];
        logic [15:0] rd;
        logic ub_s, lb_s;
        bit done;

        for (int i = 0; i < 256; i++) begin sram_mem[i] = 16'h0; ref_mem[i] = 16'h0; end
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0; be0 = 0; be1 = 0;
        sw_req[0] = 0; sw_req[1] = 0; s_addr = 20'h00100; s_wd = 16'hC3C3;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_chip_en", chip_en, 1'b1);
        chk("rst_we_n", data_enable, 1'b1);
        chk("rst_rdata0", rdata0, 16'h0000);
        chk("rst_addr", sram_address, 20'h0);

        access(0, 1, 20'h0ABCD, 16'h1234, 2'b11, lat, dl, rd, ub_s, lb_s);
        chk("wr_latency", lat, 4);
        chk("wr_strobe_width", dl, 2);
        access(0, 0, 20'h0ABCD, 16'h0000, 2'b11, lat, dl, rd, ub_s, lb_s);
        chk("rd_latency", lat, 4);
        chk("rd_data", rd, 16'h1234);

        access(0, 1, 20'h00011, 16'hBEEF, 2'b10, lat, dl, rd, ub_s, lb_s);
        chk("mask_ub", ub_s, 1'b0);
        chk("mask_lb", lb_s, 1'b1);
        access(1, 1, 20'h00022, 16'hBEEF, 2'b11, lat, dl, rd, ub_s, lb_s);
        access(1, 0, 20'h00022, 16'h0000, 2'b01, lat, dl, rd, ub_s, lb_s);
        chk("mask_rd", rd, 16'h00EF);
        access(1, 0, 20'h0ABCD, 16'h0000, 2'b00, lat, dl, rd, ub_s, lb_s);
        chk("be00_rd", rd, 16'h0000);
        chk("be00_ub", ub_s, 1'b1);

        // Port 1 streams three reads with req held.
        @(posedge clk); #2;
        req1 = 1; we1 = 0; addr1 = 20'h0ABCD; be1 = 2'b11;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(posedge clk); #1;
            if (ack1) begin t[n] = cyc; chk("b2b_rdata", rdata1, 16'h1234); n++; end
        end
        chk("b2b_count", n, 3);
        @(posedge clk); #2 req1 = 0;
        chk("b2b_gap0", t[1] - t[0], 5);
        chk("b2b_gap1", t[2] - t[1], 5);

        // Both ports request on the same edge and hold.
        @(posedge clk); #2;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 20'h0ABCD; addr1 = 20'h00022;
        be0 = 2'b11; be1 = 2'b11;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(posedge clk); #1;
            chk("dual_ack", ack0 & ack1, 1'b0);
            if (ack0 || ack1) begin gs[n] = grant; n++; end
        end
        chk("cont_count", n, 4);
        @(posedge clk); #2 req0 = 0; req1 = 0;
        chk("cont_g0", gs[0], 2'b01);
        chk("cont_g1", gs[1], 2'b10);
        chk("cont_g2", gs[2], 2'b01);
        chk("cont_g3", gs[3], 2'b10);

        // Reset during the write strobe.
        @(posedge clk); #2;
        req0 = 1; we0 = 1; addr0 = 20'h00077; wdata0 = 16'h5A5A; be0 = 2'b11;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (!data_enable) done = 1;
        end
        chk("mid_strobe_seen", done, 1'b1);
        #1 rst = 1; req0 = 0;
        @(posedge clk); #1;
        chk("mr_we_n", data_enable, 1'b1);
        chk("mr_chip_en", chip_en, 1'b1);
        chk("mr_grant", grant, 2'b00);
        chk("mr_ack", {ack0, ack1}, 2'b00);
        repeat (2) @(posedge clk);
        #2 rst = 0;
        chk("mr_rdata0", rdata0, 16'h0000);
        access(0, 0, 20'h0ABCD, 16'h0000, 2'b11, lat, dl, rd, ub_s, lb_s);
        chk("post_rst_rd", rd, 16'h1234);
        chk("post_rst_lat", lat, 4);

        // Strobe width and latency for ACCESS_CYCLES = 1 and 15.
        for (int g = 0; g < 2; g++) begin
            @(posedge clk); #2 sw_req[g] = 1;
            lat = 0; dl = 0; done = 0;
            for (int i = 0; i < 40 && !done; i++) begin
                @(posedge clk); #1;
                lat++;
                if (!sw_de[g]) dl++;
                if (sw_ack[g]) done = 1;
            end
            @(posedge clk); #2 sw_req[g] = 0;
            chk("sweep_done", done, 1'b1);
            chk("sweep_latency", lat, SW_AC[g] + 2);
            chk("sweep_strobe", dl, SW_AC[g]);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
